apb_master_fsm: RTL
===================

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN).
REQ-004 SHALL have port PCLK  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid/req_write  input  1  command valid; 1=write, 0=read.
REQ-007 SHALL have ports req_addr  input  ADDR_W and req_wdata  input  DATA_W, command address and write data.
REQ-008 SHALL have port req_ready  output  1  command accepted when high with req_valid.
REQ-009 SHALL have ports rsp_valid/rsp_err  output  1  response valid; slave error or timeout.
REQ-010 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have ports PSEL/PENABLE/PWRITE  output  1, and PADDR  output  ADDR_W, PWDATA  output  DATA_W, as APB master drives.
REQ-013 SHALL have ports PRDATA  input  DATA_W, PREADY/PSLVERR  input  1, as APB slave returns.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS, RESP.
REQ-015 SHALL assert req_ready only in IDLE; req_valid&&req_ready captures write/addr/wdata; next state SETUP.
REQ-016 SHALL drive PSEL=1, PENABLE=0 for exactly one cycle in SETUP, then enter ACCESS.
REQ-017 SHALL drive PSEL=1, PENABLE=1 in ACCESS and remain there until PREADY=1 is sampled.
REQ-018 SHALL hold PADDR, PWRITE, PWDATA constant from SETUP through the last ACCESS cycle; they hold their last values in IDLE/RESP.
REQ-019 SHALL, on PREADY in ACCESS, register rsp_rdata=PRDATA for reads (0 for writes) and rsp_err=PSLVERR, and go to RESP.
REQ-020 SHALL ignore PREADY, PRDATA, PSLVERR outside ACCESS.
REQ-021 SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err in RESP until rsp_ready=1, then go to IDLE.
REQ-022 SHALL have latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid no earlier than N+3 (zero-wait slave).
REQ-023 SHALL support back-to-back transfers: next accept no earlier than the cycle after the response handshake; PSEL low at least one cycle between transfers.
REQ-024 SHALL keep PSEL=0, PENABLE=0 in IDLE and RESP.

Reset
REQ-025 SHALL, on PRESETn low at any time (including mid-ACCESS), enter IDLE immediately with PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 after release.
REQ-026 SHALL NOT replay or report an in-flight transfer aborted by reset.

Configuration
REQ-027 SHALL, with APB_TIMEOUT_EN defined, count ACCESS cycles; if PREADY has not been seen after TIMEOUT_CYC cycles, drop PSEL/PENABLE and go to RESP with rsp_err=1, rsp_rdata=0.
REQ-028 SHALL, without APB_TIMEOUT_EN, wait in ACCESS indefinitely and contain no timeout counter.
REQ-029 SHALL give PREADY priority over timeout when both occur in the same cycle.

Structure
REQ-030 SHALL take the state enum, ADDR_W/DATA_W defaults and TIMEOUT_CYC default from shared package apb_pkg.
REQ-031 SHALL be a single module; no sub-module (the timeout counter is inline).

Verification
REQ-032 Write addr=0x10 data=0xDEADBEEF to a zero-wait slave -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-033 Read addr=0x10 with slave returning 0xDEADBEEF after 3 wait cycles -> PENABLE high 4 cycles, PADDR stable, rsp_rdata=0xDEADBEEF.
REQ-034 Read with PSLVERR=1 on the PREADY cycle -> rsp_err=1; rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0.
REQ-035 Slave never asserts PREADY, TIMEOUT_CYC=16 -> with APB_TIMEOUT_EN rsp_err=1 after 16 ACCESS cycles; without it still in ACCESS after 100 cycles.
REQ-036 PRESETn pulsed low during ACCESS of a write to 0x20 -> PSEL/PENABLE low asynchronously, no rsp_valid, next read of 0x04 completes normally.
REQ-037 Two back-to-back requests (write 0x08=0x5, read 0x08) with rsp_ready tied 1 -> PSEL low at least 1 cycle between, read returns 0x5 from the model slave.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states and default bus/timeout sizing.
package apb_pkg;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_fsm.sv
// APB master: one command in, one SETUP/ACCESS transfer out, one response back.
// Define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYC cycles without PREADY.
module apb_master_fsm
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic              PCLK,
  input  logic              PRESETn,

  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,

  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_ready,

  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("apb_master_fsm: TIMEOUT_CYC must be at least 1");
  end

  apb_state_e state;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt;
`endif

  // NOTE: every state bit and output is cleared by the async reset, so a transfer
  // cut off mid-ACCESS leaves no pending response and is never replayed.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge state and outputs update together with the state register.
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= req_write;
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
          end
        end

        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end

        ACCESS: begin
          // PREADY is checked first so a completion on the last allowed cycle wins.
          if (PREADY) begin
            state     <= RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state     <= RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
